// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, {remainder, quotient} result with 33-cycle latency
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
    state_t      state;
    logic        sdiv;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] b_abs;
    logic [64:0] work;
    logic [4:0]  cnt;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [33:0] diff;
    logic [64:0] step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    // operand magnitudes, one shift-subtract step, and the sign fix-up used on the last step
    always_comb begin
        a_in  = (signed_div && opdata1[31]) ? 32'd0 - opdata1 : opdata1;
        b_in  = (signed_div && opdata2[31]) ? 32'd0 - opdata2 : opdata2;
        diff  = work[64:31] - {2'b00, b_abs};
        step  = diff[33] ? {work[63:0], 1'b0} : {diff[32:0], work[30:0], 1'b1};
        q_fix = (sdiv && (neg_a != neg_b)) ? 32'd0 - step[31:0] : step[31:0];
        r_fix = (sdiv && neg_a) ? 32'd0 - step[63:32] : step[63:32];
    end
    // control FSM with registered ready/result; annul wins over start everywhere
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sdiv   <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_abs  <= 32'd0;
            work   <= 65'd0;
            cnt    <= 5'd0;
            result <= 64'd0;
            ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        sdiv  <= signed_div;
                        neg_a <= signed_div & opdata1[31];
                        neg_b <= signed_div & opdata2[31];
                        work  <= {33'd0, a_in};
                        b_abs <= b_in;
                        cnt   <= 5'd0;
                        state <= (opdata2 == 32'd0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        result <= 64'd0;
                        ready  <= 1'b1;
                        state  <= END;
                    end
                end
                ON: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        work <= step;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= {r_fix, q_fix};
                            ready  <= 1'b1;
                            state  <= END;
                        end
                    end
                end
                END: begin
                    if (annul || !start) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and scoreboard checks of div_unit results, latency, annul and reset
module tb_div_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic [63:0] result;
    logic        ready;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];

    div_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] r;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // start already driven at a negedge: count edges to ready, compare, hold, release
    task automatic wait_check(input int exp_lat, input string name);
        int n;
        logic [63:0] e;
        logic [63:0] held;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
                signed_div = ~signed_div;
            end
        end while (!ready && n < 100);
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        e = exp_q.pop_front();
        chk({name, " result"}, result, e);
        held = result;
        @(posedge clk);
        @(negedge clk);
        chk({name, " ready held"}, 64'(ready), 64'd1);
        chk({name, " result held"}, result, held);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, " ready drop"}, 64'(ready), 64'd0);
        chk({name, " result kept"}, result, held);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp_r, input int exp_lat, input string name);
        exp_q.push_back(exp_r);
        @(negedge clk);
        start = 1'b1;
        opdata1 = a;
        opdata2 = b;
        signed_div = s;
        annul = 1'b0;
        wait_check(exp_lat, name);
    endtask

    initial begin
        vec_t vecs[$];
        logic [63:0] prev;
        logic saw;
        vecs.push_back('{32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "u100/7"});
        vecs.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s-7/2"});
        vecs.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, "s7/-2"});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "s_min/-1"});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 33, "u_min/max"});
        vecs.push_back('{32'd5, 32'd0, 1'b1, 64'd0, 2, "s5/0"});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, "umax/1"});
        vecs.push_back('{32'd5, 32'd0, 1'b0, 64'd0, 2, "u5/0"});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'h0, 32'h1}, 33, "umax/umax"});
        vecs.push_back('{32'd1, 32'hFFFFFFFF, 1'b0, {32'h1, 32'h0}, 33, "u1/umax"});
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic s;
            a = $urandom;
            b = (i == 0) ? 32'd3 : $urandom >> $urandom_range(0, 30);
            s = i[0];
            vecs.push_back('{a, b, s, model(a, b, s), (b == 0) ? 2 : 33, "rand"});
        end

        #12;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].lat, vecs[i].name);

        // annul in ON at T+10, then an immediate new start
        prev = result;
        saw = 1'b0;
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            saw |= ready;
        end
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        saw |= ready;
        chk("annul_on no ready", 64'(saw), 64'd0);
        chk("annul_on result", result, prev);
        annul = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3; signed_div = 1'b0;
        exp_q.push_back({32'd0, 32'd3});
        wait_check(33, "after_annul 9/3");

        // annul in BYZERO
        prev = result;
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd5; opdata2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        saw = ready;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            saw |= ready;
        end
        chk("annul_byzero no ready", 64'(saw), 64'd0);
        chk("annul_byzero result", result, prev);

        // annul in END with start still high
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2; signed_div = 1'b0;
        repeat (33) @(posedge clk);
        @(negedge clk);
        chk("end8/2 ready", 64'(ready), 64'd1);
        chk("end8/2 result", result, {32'd0, 32'd4});
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("annul_end ready", 64'(ready), 64'd0);
        annul = 1'b0; start = 1'b0;

        // async reset mid-operation, then 1/1 on the first edge after release
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async rst ready", 64'(ready), 64'd0);
        chk("async rst result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1; start = 1'b1; opdata1 = 32'd1; opdata2 = 32'd1; signed_div = 1'b0;
        exp_q.push_back({32'd0, 32'd1});
        wait_check(33, "post_rst 1/1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
